// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch controller.
package stopwatch_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } sw_state_t;

   // Largest legal value of a digit: 5 for a base-6 digit, 9 otherwise.
   function automatic logic [DIGIT_W-1:0] digit_max(input logic sexa);
      return sexa ? 4'd5 : 4'd9;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the stopwatch count. Steps up or down when step_in is
// high, and raises step_out when it rolls over, so that the next digit
// steps in the same cycle. Loads saturate to the digit maximum.
module bcd_digit_cell
   import stopwatch_pkg::*;
#(
   parameter bit SEXA = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_val,
   input  logic               step_in,
   input  logic               down,
   output logic               step_out,
   output logic [DIGIT_W-1:0] value,
   output logic [DIGIT_W-1:0] nxt
);

   localparam logic [DIGIT_W-1:0] MAX = digit_max(SEXA);

   logic at_max;
   logic at_zero;

   assign at_max   = (value == MAX);
   assign at_zero  = (value == '0);
   assign step_out = step_in & (down ? at_zero : at_max);

   // Next digit value: clear beats load beats step.
   always_comb begin
      nxt = value;
      if (clr) begin
         nxt = '0;
      end else if (load) begin
         nxt = (load_val > MAX) ? MAX : load_val;
      end else if (step_in) begin
         if (down) begin
            nxt = at_zero ? MAX : value - 4'd1;
         end else begin
            nxt = at_max ? '0 : value + 4'd1;
         end
      end
   end

   // Digit register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else begin
         value <= nxt;
      end
   end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear BCD stopwatch with internal tick prescaler, up/down
// counting, saturating preset load and lap freeze. Feeds the 7-segment
// scan driver from registered values only.
module bcd_stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int                    NUM_DIGITS = 4,
   parameter int                    CLK_DIV    = 10,
   parameter logic [NUM_DIGITS-1:0] SEXA_MASK  = 4'b1000
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            key_ps_en,
   input  logic                            key_rst_en,
   input  logic                            key_lap_en,
   input  logic                            count_down,
   input  logic                            preset_load,
   input  logic [DIGIT_W*NUM_DIGITS-1:0]   preset_val,
   output logic [DIGIT_W*NUM_DIGITS-1:0]   disp_digits,
   output logic                            running,
   output logic                            lap_active,
   output logic                            wrap_pulse,
   output logic                            done_pulse
);

   localparam int CNT_W = DIGIT_W * NUM_DIGITS;
   // Keep at least one prescaler bit so CLK_DIV = 1 still elaborates.
   localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

   sw_state_t           state, state_nxt;
   logic [PW-1:0]       presc, presc_nxt;
   logic [CNT_W-1:0]    count, count_nxt;
   logic [CNT_W-1:0]    lap_reg;
   logic                lap_cap;
   logic                lap_act_nxt;
   logic                clr, load;
   logic                tick;
   logic                step0;
   logic [NUM_DIGITS:0] step_c;
   logic                cnt_zero, cnt_one;
   logic                done_nxt;
   logic                wrap_nxt;

   assign cnt_zero = (count == '0);
   assign cnt_one  = (count == CNT_W'(1));
   assign tick     = (state == ST_RUN) && (presc == PRESC_LAST);

   // Step into the least significant digit; a down-count already at zero
   // holds rather than borrowing round to all-max.
   assign step0     = tick & ~(count_down & cnt_zero);
   assign step_c[0] = step0;

   // Carry out of the top digit on an up step is exactly the all-max wrap.
   assign wrap_nxt = step_c[NUM_DIGITS] & ~count_down;

   // Digit chain, least significant first.
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit_cell #(
         .SEXA (SEXA_MASK[i])
      ) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (clr),
         .load     (load),
         .load_val (preset_val[i*DIGIT_W +: DIGIT_W]),
         .step_in  (step_c[i]),
         .down     (count_down),
         .step_out (step_c[i+1]),
         .value    (count[i*DIGIT_W +: DIGIT_W]),
         .nxt      (count_nxt[i*DIGIT_W +: DIGIT_W])
      );
   end

   // Next-state, prescaler and lap control, in priority order
   // clear > preset > tick > run/pause key > lap key.
   always_comb begin
      state_nxt   = state;
      presc_nxt   = presc;
      clr         = 1'b0;
      load        = 1'b0;
      done_nxt    = 1'b0;
      lap_cap     = 1'b0;
      lap_act_nxt = lap_active;

      if (key_rst_en) begin
         state_nxt   = ST_IDLE;
         presc_nxt   = '0;
         clr         = 1'b1;
         lap_act_nxt = 1'b0;
      end else begin
         if (state == ST_RUN) begin
            presc_nxt = tick ? '0 : presc + PW'(1);
         end

         if (preset_load && (state != ST_RUN)) begin
            load      = 1'b1;
            presc_nxt = '0;
            if (state == ST_DONE) begin
               state_nxt = ST_IDLE;
            end
         end else begin
            done_nxt = tick & count_down & (cnt_one | cnt_zero);
            if (done_nxt) begin
               state_nxt = ST_DONE;
            end else if (key_ps_en) begin
               case (state)
                  ST_IDLE:  if (!(count_down && cnt_zero)) state_nxt = ST_RUN;
                  ST_RUN:   state_nxt = ST_PAUSE;
                  ST_PAUSE: state_nxt = ST_RUN;
                  default:  state_nxt = state;
               endcase
            end
         end

         if (key_lap_en) begin
            if (!lap_active) begin
               lap_cap     = 1'b1;
               lap_act_nxt = 1'b1;
            end else begin
               lap_act_nxt = 1'b0;
            end
         end
      end
   end

   // State, prescaler, lap and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         presc      <= '0;
         lap_reg    <= '0;
         lap_active <= 1'b0;
         running    <= 1'b0;
         wrap_pulse <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         presc      <= presc_nxt;
         lap_active <= lap_act_nxt;
         running    <= (state_nxt == ST_RUN);
         wrap_pulse <= wrap_nxt;
         done_pulse <= done_nxt;
         if (clr) begin
            lap_reg <= '0;
         end else if (lap_cap) begin
            lap_reg <= count_nxt;
         end
      end
   end

   assign disp_digits = lap_active ? lap_reg : count;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl (NUM_DIGITS=4, CLK_DIV=10,
// SEXA_MASK=4'b1000).
module tb_bcd_stopwatch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_ps_en = 1'b0;
   logic        key_rst_en = 1'b0;
   logic        key_lap_en = 1'b0;
   logic        count_down = 1'b0;
   logic        preset_load = 1'b0;
   logic [15:0] preset_val = 16'h0000;
   logic [15:0] disp_digits;
   logic        running;
   logic        lap_active;
   logic        wrap_pulse;
   logic        done_pulse;

   int checks = 0;
   int errors = 0;

   bcd_stopwatch_ctrl #(
      .NUM_DIGITS (4),
      .CLK_DIV    (10),
      .SEXA_MASK  (4'b1000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_ps_en   (key_ps_en),
      .key_rst_en  (key_rst_en),
      .key_lap_en  (key_lap_en),
      .count_down  (count_down),
      .preset_load (preset_load),
      .preset_val  (preset_val),
      .disp_digits (disp_digits),
      .running     (running),
      .lap_active  (lap_active),
      .wrap_pulse  (wrap_pulse),
      .done_pulse  (done_pulse)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, landing 1 time unit after the last one.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Hold the chosen key lines high across exactly one rising edge.
   task automatic press(input logic ps, input logic rst, input logic lap, input logic ld);
      key_ps_en   = ps;
      key_rst_en  = rst;
      key_lap_en  = lap;
      preset_load = ld;
      cyc(1);
      key_ps_en   = 1'b0;
      key_rst_en  = 1'b0;
      key_lap_en  = 1'b0;
      preset_load = 1'b0;
   endtask

   task automatic test_reset();
      cyc(3);
      checks++;
      if ({disp_digits, running, lap_active, wrap_pulse, done_pulse} !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs: got disp=%h run=%b lap=%b wrap=%b done=%b, want all 0",
                  disp_digits, running, lap_active, wrap_pulse, done_pulse);
      end
      rst_n = 1'b1;
      cyc(2);
      checks++;
      if (disp_digits !== 16'h0000 || running !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_idle: got disp=%h run=%b, want 0000 0", disp_digits, running);
      end
   endtask

   task automatic test_run_pause();
      press(1, 0, 0, 0);
      cyc(100);
      checks++;
      if (disp_digits !== 16'h0010 || running !== 1'b1) begin
         errors++;
         $display("FAIL run_100: got disp=%h run=%b, want 0010 1", disp_digits, running);
      end
      press(1, 0, 0, 0);
      cyc(5);
      checks++;
      if (disp_digits !== 16'h0010 || running !== 1'b0) begin
         errors++;
         $display("FAIL pause_hold: got disp=%h run=%b, want 0010 0", disp_digits, running);
      end
   endtask

   task automatic test_partial_tick();
      press(0, 1, 0, 0);
      press(1, 0, 0, 0);
      cyc(6);
      press(1, 0, 0, 0);
      cyc(4);
      press(1, 0, 0, 0);
      checks++;
      if (running !== 1'b1 || disp_digits !== 16'h0000) begin
         errors++;
         $display("FAIL resume: got run=%b disp=%h, want 1 0000", running, disp_digits);
      end
      cyc(2);
      checks++;
      if (disp_digits !== 16'h0000) begin
         errors++;
         $display("FAIL resume_early: got %h, want 0000", disp_digits);
      end
      cyc(1);
      checks++;
      if (disp_digits !== 16'h0001) begin
         errors++;
         $display("FAIL resume_tick3: got %h, want 0001", disp_digits);
      end
   endtask

   task automatic test_wrap();
      press(0, 1, 0, 0);
      count_down = 1'b0;
      preset_val = 16'h5999;
      press(0, 0, 0, 1);
      press(1, 0, 0, 0);
      cyc(9);
      checks++;
      if (disp_digits !== 16'h5999 || wrap_pulse !== 1'b0) begin
         errors++;
         $display("FAIL pre_wrap: got disp=%h wrap=%b, want 5999 0", disp_digits, wrap_pulse);
      end
      cyc(1);
      checks++;
      if (disp_digits !== 16'h0000 || wrap_pulse !== 1'b1) begin
         errors++;
         $display("FAIL wrap: got disp=%h wrap=%b, want 0000 1", disp_digits, wrap_pulse);
      end
      cyc(1);
      checks++;
      if (wrap_pulse !== 1'b0) begin
         errors++;
         $display("FAIL wrap_width: got wrap=%b, want 0", wrap_pulse);
      end
      cyc(9);
      checks++;
      if (disp_digits !== 16'h0001) begin
         errors++;
         $display("FAIL after_wrap: got %h, want 0001", disp_digits);
      end
   endtask

   task automatic test_countdown();
      press(0, 1, 0, 0);
      count_down = 1'b1;
      press(1, 0, 0, 0);
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL down_zero_start: got run=%b, want 0", running);
      end
      preset_val = 16'h0002;
      press(0, 0, 0, 1);
      press(1, 0, 0, 0);
      cyc(10);
      checks++;
      if (disp_digits !== 16'h0001 || done_pulse !== 1'b0) begin
         errors++;
         $display("FAIL down_1: got disp=%h done=%b, want 0001 0", disp_digits, done_pulse);
      end
      cyc(10);
      checks++;
      if (disp_digits !== 16'h0000 || done_pulse !== 1'b1 || running !== 1'b0) begin
         errors++;
         $display("FAIL down_done: got disp=%h done=%b run=%b, want 0000 1 0",
                  disp_digits, done_pulse, running);
      end
      cyc(1);
      checks++;
      if (done_pulse !== 1'b0) begin
         errors++;
         $display("FAIL done_width: got done=%b, want 0", done_pulse);
      end
      press(1, 0, 0, 0);
      cyc(12);
      checks++;
      if (running !== 1'b0 || disp_digits !== 16'h0000 || done_pulse !== 1'b0) begin
         errors++;
         $display("FAIL done_ignores_ps: got run=%b disp=%h done=%b, want 0 0000 0",
                  running, disp_digits, done_pulse);
      end
      preset_val = 16'h0003;
      press(0, 0, 0, 1);
      checks++;
      if (disp_digits !== 16'h0003) begin
         errors++;
         $display("FAIL done_preset: got %h, want 0003", disp_digits);
      end
      press(1, 0, 0, 0);
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL idle_after_done: got run=%b, want 1", running);
      end
      count_down = 1'b0;
      press(0, 1, 0, 0);
   endtask

   task automatic test_preset_sat();
      preset_val = 16'hFA7C;
      press(0, 0, 0, 1);
      checks++;
      if (disp_digits !== 16'h5979) begin
         errors++;
         $display("FAIL preset_sat: got %h, want 5979", disp_digits);
      end
      press(1, 0, 0, 0);
      cyc(3);
      preset_val = 16'h1234;
      press(0, 0, 0, 1);
      checks++;
      if (disp_digits !== 16'h5979 || running !== 1'b1) begin
         errors++;
         $display("FAIL preset_in_run: got disp=%h run=%b, want 5979 1", disp_digits, running);
      end
      cyc(6);
      checks++;
      if (disp_digits !== 16'h5980) begin
         errors++;
         $display("FAIL preset_run_tick: got %h, want 5980", disp_digits);
      end
      press(0, 1, 0, 0);
   endtask

   task automatic test_lap();
      preset_val = 16'h0120;
      press(0, 0, 0, 1);
      press(1, 0, 0, 0);
      cyc(30);
      press(0, 0, 1, 0);
      checks++;
      if (disp_digits !== 16'h0123 || lap_active !== 1'b1) begin
         errors++;
         $display("FAIL lap_capture: got disp=%h lap=%b, want 0123 1", disp_digits, lap_active);
      end
      cyc(19);
      checks++;
      if (disp_digits !== 16'h0123) begin
         errors++;
         $display("FAIL lap_frozen: got %h, want 0123", disp_digits);
      end
      press(0, 0, 1, 0);
      checks++;
      if (disp_digits !== 16'h0125 || lap_active !== 1'b0) begin
         errors++;
         $display("FAIL lap_release: got disp=%h lap=%b, want 0125 0", disp_digits, lap_active);
      end
      press(0, 0, 1, 0);
      press(0, 1, 0, 0);
      checks++;
      if (disp_digits !== 16'h0000 || lap_active !== 1'b0 || running !== 1'b0) begin
         errors++;
         $display("FAIL lap_rst: got disp=%h lap=%b run=%b, want 0000 0 0",
                  disp_digits, lap_active, running);
      end
      press(0, 1, 1, 0);
      checks++;
      if (lap_active !== 1'b0) begin
         errors++;
         $display("FAIL rst_drops_lap: got lap=%b, want 0", lap_active);
      end
   endtask

   task automatic test_back_to_back();
      press(1, 0, 0, 0);
      cyc(9);
      press(0, 0, 1, 0);
      checks++;
      if (disp_digits !== 16'h0001 || lap_active !== 1'b1) begin
         errors++;
         $display("FAIL lap_on_tick: got disp=%h lap=%b, want 0001 1", disp_digits, lap_active);
      end
      cyc(9);
      press(1, 0, 0, 0);
      checks++;
      if (running !== 1'b0 || disp_digits !== 16'h0001) begin
         errors++;
         $display("FAIL ps_on_tick: got run=%b disp=%h, want 0 0001", running, disp_digits);
      end
      press(0, 0, 1, 0);
      checks++;
      if (disp_digits !== 16'h0002) begin
         errors++;
         $display("FAIL tick_before_pause: got %h, want 0002", disp_digits);
      end
   endtask

   initial begin
      test_reset();
      test_run_pause();
      test_partial_tick();
      test_wrap();
      test_countdown();
      test_preset_sat();
      test_lap();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
